// File: rtl/rv32_mod_data_mem_pkg.sv
// Shared dext bus types: transfer record, responder FSM states, lane constants.
package rv32_dext_pkg;

   localparam int         DEXT_IDX_W  = 30;
   localparam logic [3:0] DEXT_BE_ALL = 4'b1111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_e;

   // idx is the word offset from BASE_ADDR; only the low log2(depth) bits address the array
   typedef struct packed {
      logic                  wr;
      logic [3:0]            be;
      logic [DEXT_IDX_W-1:0] idx;
      logic [31:0]           wdata;
      logic                  err;
   } dext_xfer_t;

endpackage

// File: rtl/rv32_mod_data_mem_if.sv
// dext bus bundle: initiator (master) drives requests, memory (slave) drives responses.
interface rv32_mod_data_mem_if;
   logic        dext_req;
   logic        dext_wr;
   logic [3:0]  dext_be;
   logic [31:0] dext_addr;
   logic [31:0] dext_do;
   logic        dext_ack;
   logic        dext_err;
   logic [31:0] dext_di;
   logic        overflow;

   modport master (
      output dext_req, dext_wr, dext_be, dext_addr, dext_do,
      input  dext_ack, dext_err, dext_di, overflow
   );

   modport slave (
      input  dext_req, dext_wr, dext_be, dext_addr, dext_do,
      output dext_ack, dext_err, dext_di, overflow
   );
endinterface

// File: rtl/rv32_mod_dmem_array.sv
// Byte-enabled word array: combinational read, one synchronous byte-masked write port.
module rv32_mod_dmem_array #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] idx,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/rv32_mod_data_mem.sv
// dext data memory responder with wait states and a one-deep pending slot.
// Optional write protection of the low WPROT_WORDS words under RV32_DMEM_WPROT_EN.
module rv32_mod_data_mem
   import rv32_dext_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_STATES = 0,
   parameter int          WPROT_WORDS = 256
) (
   input  logic               clk,
   input  logic               reset,
   rv32_mod_data_mem_if.slave bus
);

   localparam int          AW       = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
   localparam dmem_state_e START_ST = (WAIT_STATES > 0) ? WAIT : RESP;

   dmem_state_e state;
   dmem_state_e state_nxt;
   dext_xfer_t  cur;
   dext_xfer_t  pend;
   dext_xfer_t  req_x;
   logic        pend_vld;
   logic [3:0]  cnt;
   logic        ovf_q;
   logic [31:0] off;
   logic [31:0] rdata;
   logic        we;
   logic        ack;
   logic        err;
   logic [31:0] di;
   logic        unused_bits;

   // Error classification happens once, at capture, so later stages only carry a flag
   always_comb begin
      off         = bus.dext_addr - BASE_ADDR;
      req_x       = '0;
      req_x.wr    = bus.dext_wr;
      req_x.be    = bus.dext_be;
      req_x.idx   = off[31:2];
      req_x.wdata = bus.dext_do;
      req_x.err   = (off[31:2] >= 30'(DEPTH_WORDS));
`ifdef RV32_DMEM_WPROT_EN
      if (bus.dext_wr && (off[31:2] < 30'(WPROT_WORDS))) req_x.err = 1'b1;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.dext_req) state_nxt = START_ST;
         WAIT:    if (cnt == 4'd0) state_nxt = RESP;
         RESP:    state_nxt = (pend_vld || bus.dext_req) ? START_ST : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A request seen in RESP with an empty slot is taken straight into cur for full throughput
   always_ff @(posedge clk) begin
      if (reset) begin
         cur      <= '0;
         pend     <= '0;
         pend_vld <= 1'b0;
         cnt      <= 4'd0;
         ovf_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.dext_req) begin
                  cur <= req_x;
                  cnt <= CNT_LOAD;
               end
            end
            WAIT: begin
               if (cnt != 4'd0) cnt <= cnt - 4'd1;
               if (bus.dext_req) begin
                  if (pend_vld) begin
                     ovf_q <= 1'b1;
                  end else begin
                     pend     <= req_x;
                     pend_vld <= 1'b1;
                  end
               end
            end
            RESP: begin
               if (pend_vld) begin
                  cur      <= pend;
                  cnt      <= CNT_LOAD;
                  pend_vld <= bus.dext_req;
                  if (bus.dext_req) pend <= req_x;
               end else if (bus.dext_req) begin
                  cur <= req_x;
                  cnt <= CNT_LOAD;
               end
            end
            default: ;
         endcase
      end
   end

   // Reset in the RESP cycle aborts the transfer: no response and no commit
   always_comb begin
      ack = 1'b0;
      err = 1'b0;
      di  = 32'h0;
      if ((state == RESP) && !reset) begin
         if (cur.err) begin
            err = 1'b1;
         end else begin
            ack = 1'b1;
            if (!cur.wr) di = rdata;
         end
      end
   end

   assign we = (state == RESP) && cur.wr && !cur.err && !reset;

   rv32_mod_dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_array (
      .clk   (clk),
      .we    (we),
      .be    (cur.be),
      .idx   (cur.idx[AW-1:0]),
      .wdata (cur.wdata),
      .rdata (rdata)
   );

   assign bus.dext_ack = ack;
   assign bus.dext_err = err;
   assign bus.dext_di  = di;
   assign bus.overflow = ovf_q;

   assign unused_bits = ^{cur.idx[DEXT_IDX_W-1:AW], off[1:0], 32'(WPROT_WORDS)};

endmodule

// File: tb/tb_rv32_mod_data_mem.sv
// Bench for rv32_mod_data_mem: three instances (0, 2, 3 wait states) against a word-array model.
module tb_rv32_mod_data_mem;
   import rv32_dext_pkg::*;

   localparam logic [31:0] BASE  = 32'h2000_0000;
   localparam int          DEPTH = 1024;
   localparam int          WPROT = 256;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   rv32_mod_data_mem_if if0 ();
   rv32_mod_data_mem_if if2 ();
   rv32_mod_data_mem_if if3 ();

   rv32_mod_data_mem #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0), .WPROT_WORDS(WPROT))
      u_w0 (.clk(clk), .reset(reset), .bus(if0.slave));
   rv32_mod_data_mem #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(2), .WPROT_WORDS(WPROT))
      u_w2 (.clk(clk), .reset(reset), .bus(if2.slave));
   rv32_mod_data_mem #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3), .WPROT_WORDS(WPROT))
      u_w3 (.clk(clk), .reset(reset), .bus(if3.slave));

   always #5 clk = ~clk;

   logic [31:0] model_mem [int];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int sel, input logic req, input logic wr, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] data);
      case (sel)
         0: begin if0.dext_req = req; if0.dext_wr = wr; if0.dext_be = be; if0.dext_addr = addr; if0.dext_do = data; end
         2: begin if2.dext_req = req; if2.dext_wr = wr; if2.dext_be = be; if2.dext_addr = addr; if2.dext_do = data; end
         default: begin if3.dext_req = req; if3.dext_wr = wr; if3.dext_be = be; if3.dext_addr = addr; if3.dext_do = data; end
      endcase
   endtask

   task automatic sample(input int sel, output logic ack, output logic err, output logic [31:0] di, output logic ovf);
      #1;
      case (sel)
         0:       begin ack = if0.dext_ack; err = if0.dext_err; di = if0.dext_di; ovf = if0.overflow; end
         2:       begin ack = if2.dext_ack; err = if2.dext_err; di = if2.dext_di; ovf = if2.overflow; end
         default: begin ack = if3.dext_ack; err = if3.dext_err; di = if3.dext_di; ovf = if3.overflow; end
      endcase
   endtask

   // One transfer; returns the outputs seen in the cycle the response is due (request + 1 + w)
   task automatic xfer(input int sel, input int w, input logic wr, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] data,
                       output logic ack, output logic err, output logic [31:0] di);
      logic ovf;
      drive(sel, 1'b1, wr, be, addr, data);
      step();
      drive(sel, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      repeat (w) step();
      sample(sel, ack, err, di, ovf);
   endtask

   function automatic logic model_err(input logic wr, input logic [31:0] addr);
      logic [31:0] off;
      off = addr - BASE;
      if ((off >> 2) >= 32'(DEPTH)) return 1'b1;
`ifdef RV32_DMEM_WPROT_EN
      if (wr && ((off >> 2) < 32'(WPROT))) return 1'b1;
`endif
      return 1'b0 & wr;
   endfunction

   task automatic test_reset();
      logic a, e, o;
      logic [31:0] d;
      reset = 1'b1;
      drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      drive(2, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      drive(3, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      step();
      step();
      reset = 1'b0;
      step();
      for (int s = 0; s < 4; s++) begin
         if (s == 1) continue;
         sample(s, a, e, d, o);
         checks++; if (a !== 1'b0) begin failures++; $display("FAIL reset_ack dut%0d got %b want 0", s, a); end
         checks++; if (e !== 1'b0) begin failures++; $display("FAIL reset_err dut%0d got %b want 0", s, e); end
         checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_di dut%0d got %h want 0", s, d); end
         checks++; if (o !== 1'b0) begin failures++; $display("FAIL reset_ovf dut%0d got %b want 0", s, o); end
      end
   endtask

   task automatic test_write_read();
      logic a, e, o;
      logic [31:0] d;
      xfer(0, 0, 1'b1, DEXT_BE_ALL, BASE + 32'h400, 32'hDEADBEEF, a, e, d);
      checks++; if ({a, e} !== 2'b10) begin failures++; $display("FAIL wr_ack got ack=%b err=%b want 1/0", a, e); end
      xfer(0, 0, 1'b0, DEXT_BE_ALL, BASE + 32'h400, 32'h0, a, e, d);
      checks++; if (a !== 1'b1) begin failures++; $display("FAIL rd_ack got %b want 1", a); end
      checks++; if (d !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got %h want deadbeef", d); end
      step();
      sample(0, a, e, d, o);
      checks++; if ({a, e, d} !== 34'h0) begin failures++; $display("FAIL single_pulse got ack=%b err=%b di=%h want 0", a, e, d); end
   endtask

   task automatic test_byte_enable();
      logic a, e;
      logic [31:0] d;
      xfer(0, 0, 1'b1, 4'hF, BASE + 32'h404, 32'h11223344, a, e, d);
      xfer(0, 0, 1'b1, 4'b0100, BASE + 32'h404, 32'h00AA0000, a, e, d);
      checks++; if (a !== 1'b1) begin failures++; $display("FAIL be_wr_ack got %b want 1", a); end
      xfer(0, 0, 1'b0, 4'hF, BASE + 32'h404, 32'h0, a, e, d);
      checks++; if (d !== 32'h11AA3344) begin failures++; $display("FAIL be_merge got %h want 11aa3344", d); end
      xfer(0, 0, 1'b1, 4'b0000, BASE + 32'h404, 32'hFFFFFFFF, a, e, d);
      checks++; if ({a, e} !== 2'b10) begin failures++; $display("FAIL be0_ack got ack=%b err=%b want 1/0", a, e); end
      xfer(0, 0, 1'b0, 4'b0000, BASE + 32'h407, 32'h0, a, e, d);
      checks++; if (d !== 32'h11AA3344) begin failures++; $display("FAIL be0_read got %h want 11aa3344", d); end
   endtask

   task automatic test_out_of_range();
      logic a, e;
      logic [31:0] d;
      xfer(0, 0, 1'b0, 4'hF, BASE + 32'(4 * DEPTH), 32'h0, a, e, d);
      checks++; if ({a, e} !== 2'b01) begin failures++; $display("FAIL oor_rd got ack=%b err=%b want 0/1", a, e); end
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL oor_rd_di got %h want 0", d); end
      xfer(0, 0, 1'b1, 4'hF, BASE + 32'(4 * DEPTH) + 32'h400, 32'h0, a, e, d);
      checks++; if ({a, e} !== 2'b01) begin failures++; $display("FAIL oor_wr got ack=%b err=%b want 0/1", a, e); end
      xfer(0, 0, 1'b1, 4'hF, BASE - 32'h4, 32'h0, a, e, d);
      checks++; if ({a, e} !== 2'b01) begin failures++; $display("FAIL below_base got ack=%b err=%b want 0/1", a, e); end
      xfer(0, 0, 1'b0, 4'hF, BASE + 32'h400, 32'h0, a, e, d);
      checks++; if (d !== 32'hDEADBEEF) begin failures++; $display("FAIL oor_no_alias got %h want deadbeef", d); end
`ifdef RV32_DMEM_WPROT_EN
      xfer(0, 0, 1'b1, 4'hF, BASE, 32'h12345678, a, e, d);
      checks++; if ({a, e} !== 2'b01) begin failures++; $display("FAIL wprot_wr got ack=%b err=%b want 0/1", a, e); end
      xfer(0, 0, 1'b0, 4'hF, BASE, 32'h0, a, e, d);
      checks++; if ({a, e} !== 2'b10) begin failures++; $display("FAIL wprot_rd got ack=%b err=%b want 1/0", a, e); end
      checks++; if (d === 32'h12345678) begin failures++; $display("FAIL wprot_kept got %h want not 12345678", d); end
`endif
   endtask

   task automatic test_wait_states();
      logic a, e, o;
      logic [31:0] d;
      xfer(3, 3, 1'b1, 4'hF, BASE + 32'h500, 32'hCAFEF00D, a, e, d);
      checks++; if (a !== 1'b1) begin failures++; $display("FAIL w3_wr_ack got %b want 1", a); end
      step();
      drive(3, 1'b1, 1'b0, 4'hF, BASE + 32'h500, 32'h0);
      for (int c = 1; c <= 7; c++) begin
         step();
         if (c == 1) drive(3, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
         sample(3, a, e, d, o);
         checks++;
         if (a !== (c == 4) || e !== 1'b0 || d !== ((c == 4) ? 32'hCAFEF00D : 32'h0)) begin
            failures++;
            $display("FAIL w3_timing cycle %0d got ack=%b err=%b di=%h want ack=%0d", c, a, e, d, c == 4);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic a, e, o;
      logic [31:0] d;
      xfer(2, 2, 1'b1, 4'hF, BASE + 32'h608, 32'h5A5A5A5A, a, e, d);
      checks++; if (a !== 1'b1) begin failures++; $display("FAIL w2_setup_ack got %b want 1", a); end
      step();
      drive(2, 1'b1, 1'b1, 4'hF, BASE + 32'h600, 32'h11111111);
      for (int c = 1; c <= 8; c++) begin
         step();
         case (c)
            1:       drive(2, 1'b1, 1'b1, 4'hF, BASE + 32'h604, 32'h22222222);
            2:       drive(2, 1'b1, 1'b1, 4'hF, BASE + 32'h608, 32'h33333333);
            default: drive(2, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
         endcase
         sample(2, a, e, d, o);
         checks++;
         if (a !== (c == 3 || c == 6) || e !== 1'b0 || o !== (c >= 3)) begin
            failures++;
            $display("FAIL b2b cycle %0d got ack=%b err=%b ovf=%b", c, a, e, o);
         end
      end
      xfer(2, 2, 1'b0, 4'hF, BASE + 32'h600, 32'h0, a, e, d);
      checks++; if (d !== 32'h11111111) begin failures++; $display("FAIL b2b_first got %h want 11111111", d); end
      xfer(2, 2, 1'b0, 4'hF, BASE + 32'h604, 32'h0, a, e, d);
      checks++; if (d !== 32'h22222222) begin failures++; $display("FAIL b2b_second got %h want 22222222", d); end
      xfer(2, 2, 1'b0, 4'hF, BASE + 32'h608, 32'h0, a, e, d);
      checks++; if (d !== 32'h5A5A5A5A) begin failures++; $display("FAIL b2b_dropped got %h want 5a5a5a5a", d); end
      sample(2, a, e, d, o);
      checks++; if (o !== 1'b1) begin failures++; $display("FAIL ovf_sticky got %b want 1", o); end
      step();
   endtask

   task automatic test_reset_in_resp();
      logic a, e, o;
      logic [31:0] d;
      xfer(0, 0, 1'b1, 4'hF, BASE + 32'h700, 32'h12345678, a, e, d);
      drive(0, 1'b1, 1'b1, 4'hF, BASE + 32'h700, 32'h87654321);
      step();
      drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      reset = 1'b1;
      sample(0, a, e, d, o);
      checks++; if (a !== 1'b0) begin failures++; $display("FAIL rst_resp_ack got %b want 0", a); end
      step();
      reset = 1'b0;
      sample(0, a, e, d, o);
      checks++; if ({a, e, d, o} !== 35'h0) begin failures++; $display("FAIL rst_outputs got ack=%b err=%b di=%h ovf=%b want 0", a, e, d, o); end
      sample(2, a, e, d, o);
      checks++; if (o !== 1'b0) begin failures++; $display("FAIL rst_ovf_clear got %b want 0", o); end
      xfer(0, 0, 1'b0, 4'hF, BASE + 32'h700, 32'h0, a, e, d);
      checks++; if ({a, d} !== {1'b1, 32'h12345678}) begin failures++; $display("FAIL rst_no_commit got ack=%b di=%h want 1/12345678", a, d); end
   endtask

   task automatic test_random();
      logic a, e, o;
      logic [31:0] d;
      logic exp_ack = 1'b0;
      logic exp_err = 1'b0;
      logic [31:0] exp_di = 32'h0;
      logic req, wr;
      logic [3:0] be;
      logic [31:0] addr, data, word;
      int idx;
      step();
      for (int i = 0; i < 300; i++) begin
         sample(0, a, e, d, o);
         checks++;
         if (a !== exp_ack || e !== exp_err || d !== exp_di) begin
            failures++;
            $display("FAIL rand iter %0d got ack=%b err=%b di=%h want ack=%b err=%b di=%h", i, a, e, d, exp_ack, exp_err, exp_di);
         end
         if (i < 16) begin
            req = 1'b1; wr = 1'b1; be = 4'hF;
            addr = BASE + 32'((300 + i) * 4);
         end else begin
            req  = ($urandom_range(4) != 0);
            wr   = $urandom_range(1);
            be   = 4'($urandom_range(15));
            if ($urandom_range(9) == 0)
               addr = $urandom_range(1) ? BASE + 32'(4 * DEPTH) + 32'($urandom_range(63) * 4)
                                        : BASE - 32'(4 * (1 + $urandom_range(7)));
            else
               addr = BASE + 32'((300 + $urandom_range(15)) * 4) + 32'($urandom_range(3));
         end
         data = $urandom;
         exp_ack = 1'b0; exp_err = 1'b0; exp_di = 32'h0;
         if (req) begin
            if (model_err(wr, addr)) begin
               exp_err = 1'b1;
            end else begin
               exp_ack = 1'b1;
               idx = int'((addr - BASE) >> 2);
               if (wr) begin
                  word = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
                  for (int b = 0; b < 4; b++) if (be[b]) word[8*b +: 8] = data[8*b +: 8];
                  model_mem[idx] = word;
               end else begin
                  exp_di = model_mem[idx];
               end
            end
         end
         drive(0, req, wr, be, addr, data);
         step();
      end
      drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      sample(0, a, e, d, o);
      checks++;
      if (a !== exp_ack || e !== exp_err || d !== exp_di) begin
         failures++;
         $display("FAIL rand_last got ack=%b err=%b di=%h want ack=%b err=%b di=%h", a, e, d, exp_ack, exp_err, exp_di);
      end
      checks++; if (o !== 1'b0) begin failures++; $display("FAIL rand_no_ovf got %b want 0", o); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_enable();
      test_out_of_range();
      test_wait_states();
      test_back_to_back();
      test_reset_in_resp();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
